// File: rtl/uart_mem_dump_tx_pkg.sv
// Shared UART dump definitions: FSM/phase encodings, frame constants, byte select helper.
package uart_mem_dump_tx_pkg;

  localparam int   UART_DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;

  // Nine states including CKSUM, so the encoding needs four bits.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_WAIT_MEM = 4'd2,
    ST_START    = 4'd3,
    ST_DATA     = 4'd4,
    ST_STOP     = 4'd5,
    ST_NEXT     = 4'd6,
    ST_FINISH   = 4'd7,
    ST_CKSUM    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    TXP_IDLE  = 2'd0,
    TXP_START = 2'd1,
    TXP_DATA  = 2'd2,
    TXP_STOP  = 2'd3
  } tx_phase_e;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: owns the baud counter and shift register.
// A load in the last stop-bit cycle starts the next frame with no idle gap.
module uart_tx_byte
  import uart_mem_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done,
  output tx_phase_e  phase
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_done = (phase == TXP_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase   <= TXP_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= UART_IDLE_LEVEL;
    end else if (load) begin
      phase   <= TXP_START;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= data;
      tx      <= 1'b0;
    end else begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
      case (phase)
        TXP_IDLE: begin
          cnt <= '0;
          tx  <= UART_IDLE_LEVEL;
        end
        TXP_START: if (bit_end) begin
          phase <= TXP_DATA;
          tx    <= shreg[0];
        end
        TXP_DATA: if (bit_end) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            phase <= TXP_STOP;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= shreg[1];
            shreg   <= shreg >> 1;
          end
        end
        TXP_STOP: if (bit_end) phase <= TXP_IDLE;
        default: phase <= TXP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_dump_tx.sv
// Memory dump over UART TX: fetches words and sends them LSB byte first as 8N1 frames.
// Define UART_DUMP_CHECKSUM_EN to append an XOR checksum frame after the data.
module uart_mem_dump_tx
  import uart_mem_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_WIDTH   = 8,
  parameter int CNT_WIDTH    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  state_e               state;
  logic [31:0]          word;
  logic [1:0]           byte_idx;
  logic [CNT_WIDTH-1:0] remain;
  logic                 load;
  logic [7:0]           load_data;
  logic                 byte_done;
  tx_phase_e            phase;
  logic                 last_byte;
  logic                 more_words;

  assign last_byte  = (byte_idx == 2'd3);
  assign more_words = (remain > CNT_WIDTH'(1));

`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0] cksum;
`endif

  // Next-byte loads are issued in the final stop cycle so frames within a word abut.
  always_comb begin
    load      = 1'b0;
    load_data = byte_sel(word, byte_idx + 2'd1);
    case (state)
      ST_WAIT_MEM: begin
        load      = 1'b1;
        load_data = mem_rdata[7:0];
      end
      ST_STOP: load = byte_done && !last_byte;
`ifdef UART_DUMP_CHECKSUM_EN
      ST_IDLE: begin
        load      = start && (word_count == '0);
        load_data = 8'h00;
      end
      ST_NEXT: begin
        load      = last_byte && !more_words;
        load_data = cksum;
      end
`endif
      default: ;
    endcase
  end

`ifdef UART_DUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst)
      cksum <= '0;
    else if (state == ST_IDLE && start)
      cksum <= '0;
    else if (load && (state == ST_WAIT_MEM || state == ST_STOP))
      cksum <= cksum ^ load_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      word      <= '0;
      byte_idx  <= '0;
      remain    <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy <= 1'b1;
          if (word_count != '0) begin
            mem_addr  <= base_addr;
            remain    <= word_count;
            mem_rd_en <= 1'b1;
            state     <= ST_FETCH;
          end
`ifdef UART_DUMP_CHECKSUM_EN
          else state <= ST_CKSUM;
`else
          else begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end
`endif
        end
        ST_FETCH: state <= ST_WAIT_MEM;
        ST_WAIT_MEM: begin
          word     <= mem_rdata;
          byte_idx <= '0;
          state    <= ST_START;
        end
        ST_START: if (phase == TXP_DATA) state <= ST_DATA;
        ST_DATA:  if (phase == TXP_STOP) state <= ST_STOP;
        ST_STOP:  if (byte_done) state <= ST_NEXT;
        ST_NEXT: begin
          if (!last_byte) begin
            byte_idx <= byte_idx + 2'd1;
            state    <= ST_START;
          end else if (more_words) begin
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            remain    <= remain - CNT_WIDTH'(1);
            mem_rd_en <= 1'b1;
            state     <= ST_FETCH;
          end else begin
`ifdef UART_DUMP_CHECKSUM_EN
            state <= ST_CKSUM;
`else
            state <= ST_FINISH;
            done  <= 1'b1;
`endif
          end
        end
        ST_CKSUM: if (byte_done) begin
          state <= ST_FINISH;
          done  <= 1'b1;
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (load_data),
    .tx        (tx),
    .byte_done (byte_done),
    .phase     (phase)
  );

endmodule

// File: tb/tb_uart_mem_dump_tx.sv
// Bench for uart_mem_dump_tx: UART decoder + scoreboard, table of dump transactions, reset corners.
module tb_uart_mem_dump_tx;

  localparam int CPB = 4;
`ifdef UART_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        tx, busy, done;

  uart_mem_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .CNT_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  int         fs_q[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (rst === 1'b1 && mem_rd_en === 1'b1) rd_q.push_back(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART decoder: samples each bit mid-cell on the falling clock edge.
  initial begin
    int t0;
    logic [7:0] b;
    logic sb, st_ok;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        t0 = cyc; b = '0; sb = 1'b0; st_ok = 1'b0; ab = 0;
        for (int off = 1; off < 10*CPB; off++) begin
          @(negedge clk);
          if (rst !== 1'b1) ab = 1;
          if (off == CPB/2) st_ok = (tx === 1'b0);
          if (off >= CPB + CPB/2 && ((off - CPB - CPB/2) % CPB) == 0 && off < 9*CPB)
            b[(off - CPB - CPB/2) / CPB] = tx;
          if (off == 9*CPB + CPB/2) sb = tx;
        end
        if (!ab) begin
          fs_q.push_back(t0);
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_frame: got %0h expected no frame (cycle %0d)", b, cyc);
          end else begin
            chk("tx_byte", b, exp_q.pop_front());
          end
          chk("start_bit", st_ok, 1);
          chk("stop_bit", sb, 1);
        end
      end
    end
  end

  task automatic push_expected(input logic [7:0] base, input logic [8:0] cnt);
    logic [7:0] acc, a, bv;
    acc = '0;
    for (int i = 0; i < cnt; i++) begin
      a = base + 8'(i);
      for (int k = 0; k < 4; k++) begin
        bv = mem[a][8*k +: 8];
        exp_q.push_back(bv);
        acc ^= bv;
      end
    end
    if (CK != 0) exp_q.push_back(acc);
  endtask

  task automatic pulse_start(input logic [7:0] base, input logic [8:0] cnt, output int t_acc);
    @(negedge clk);
    base_addr = base; word_count = cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic run_txn(input logic [7:0] base, input logic [8:0] cnt, input bit mid, input int exp_busy);
    int t_acc, t, nfr, dt;
    logic [7:0] ea;
    exp_q.delete(); rd_q.delete(); fs_q.delete();
    busy_cnt = 0; done_cnt = 0;
    push_expected(base, cnt);
    pulse_start(base, cnt, t_acc);
    t = 0;
    while (done !== 1'b1 && t < 3000) begin
      if (mid && t == 60) begin base_addr = 8'h33; word_count = 9'd4; start = 1'b1; end
      if (mid && t == 61) start = 1'b0;
      @(negedge clk);
      t++;
    end
    chk("done_seen", (t < 3000), 1);
    repeat (4) @(negedge clk);
    chk("busy_cycles", busy_cnt, exp_busy + CK*10*CPB);
    chk("done_pulses", done_cnt, 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("busy_after", busy, 0);
    chk("tx_idle_after", tx, 1);
    chk("read_count", rd_q.size(), cnt);
    for (int i = 0; i < rd_q.size() && i < cnt; i++) begin
      ea = base + 8'(i);
      chk("read_addr", rd_q[i], ea);
    end
    nfr = 4*cnt + CK;
    chk("frame_count", fs_q.size(), nfr);
    if (fs_q.size() == nfr && nfr > 0) begin
      chk("first_frame_lat", fs_q[0] - t_acc, (cnt > 0) ? 2 : 0);
      for (int j = 1; j < nfr; j++) begin
        if (j == 4*cnt) dt = 10*CPB + 1;
        else if (j % 4 == 0) dt = 10*CPB + 3;
        else dt = 10*CPB;
        chk("frame_spacing", fs_q[j] - fs_q[j-1], dt);
      end
    end
  endtask

  typedef struct {
    logic [7:0] base;
    logic [8:0] count;
    bit         mid_start;
    int         exp_busy;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t_acc;
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)};
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'hFF] = 32'h11223344;
    mem[8'h00] = 32'h55667788;
    vecs[0] = '{8'h10, 9'd1, 1'b0, 164};
    vecs[1] = '{8'hFF, 9'd2, 1'b0, 327};
    vecs[2] = '{8'h20, 9'd0, 1'b0, 1};
    vecs[3] = '{8'h40, 9'd3, 1'b1, 490};

    // Reset held three cycles, then released
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0); chk("rst_addr", mem_addr, 0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rel_tx", tx, 1); chk("rel_busy", busy, 0); chk("rel_done", done, 0);
      chk("rel_rd_en", mem_rd_en, 0);
    end

    for (int v = 0; v < 4; v++) begin
      run_txn(vecs[v].base, vecs[v].count, vecs[v].mid_start, vecs[v].exp_busy);
      repeat (5) @(negedge clk);
    end

    // Reset during data bit 3 of byte 1
    exp_q.delete(); fs_q.delete(); done_cnt = 0;
    push_expected(8'h10, 9'd1);
    pulse_start(8'h10, 9'd1, t_acc);
    repeat (2 + 10*CPB + CPB + 3*CPB + 1 - 1) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", mem_rd_en, 0);
    chk("midrst_frames", fs_q.size(), 1);
    chk("midrst_bytes_left", exp_q.size(), 3 + CK);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_tx_idle", tx, 1);
    run_txn(8'h10, 9'd1, 1'b0, 164);

    // Small known word; checksum builds also expect a trailing 0x04 frame
    mem[8'h00] = 32'h01020304;
    run_txn(8'h00, 9'd1, 1'b0, 164);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
